// File: rtl/i2c_cfg_pkg.sv
// Shared types and the codec init table for the I2C configuration sequencer.
// Table entries are 16-bit {register address, value} words sent after the device address.
package i2c_cfg_pkg;

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  localparam int CFG_ENTRIES = 16;

  localparam logic [15:0] CFG_TABLE [CFG_ENTRIES] = '{
    16'h0c10, 16'h0017, 16'h0217, 16'h0479, 16'h0679, 16'h08d0, 16'h0a04, 16'h0e01,
    16'h1020, 16'h0c00, 16'h1201, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000
  };

  function automatic logic [15:0] cfg_word(input logic [4:0] idx);
    return CFG_TABLE[idx[3:0]];
  endfunction

endpackage

// File: rtl/i2c_cfg_sequencer.sv
// Walks the init table over an external I2C controller, retrying NACKed transfers,
// then serves single runtime register writes until restarted.
module i2c_cfg_sequencer
  import i2c_cfg_pkg::*;
#(
  parameter int          DEPTH     = 11,
  parameter logic [7:0]  DEV_ADDR  = 8'h34,
  parameter int          MAX_RETRY = 3,
  localparam int         IDX_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  input  logic             usr_valid,
  input  logic [15:0]      usr_data,
  output logic             usr_ready,
  output logic             i2c_start,
  output logic [23:0]      i2c_data,
  input  logic             i2c_done,
  input  logic             i2c_ack,
  output logic             busy,
  output logic             init_done,
  output logic             error,
  output logic [IDX_W-1:0] err_index,
  output logic [IDX_W-1:0] status
);

  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_t             state, state_next;
  logic [RTY_W-1:0]   retry, retry_nxt;
  logic [15:0]        usr_word, usr_word_nxt;
  logic [IDX_W-1:0]   status_nxt, err_index_nxt;
  logic [23:0]        i2c_data_nxt;
  logic               start_nxt, init_done_nxt, error_nxt, usr_ready_nxt, busy_nxt;

  logic is_user, is_last, done_seen, can_retry;

  // A done coincident with our own start pulse belongs to no transfer of ours.
  assign done_seen = i2c_done && !i2c_start;
  assign is_user   = (status == IDX_W'(DEPTH));
  assign is_last   = (status == IDX_W'(DEPTH - 1));
  assign can_retry = (int'(retry) < MAX_RETRY);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_ISSUE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT: begin
        if (done_seen) begin
          if (i2c_ack)        state_next = (is_user || is_last) ? ST_READY : ST_ISSUE;
          else if (can_retry) state_next = ST_ISSUE;
          else                state_next = ST_ERROR;
        end
      end
      ST_READY: if (restart || usr_valid) state_next = ST_ISSUE;
      ST_ERROR: if (restart)              state_next = ST_ISSUE;
      default:  state_next = ST_ISSUE;
    endcase
  end

  always_comb begin
    status_nxt    = status;
    retry_nxt     = retry;
    start_nxt     = 1'b0;
    i2c_data_nxt  = i2c_data;
    init_done_nxt = init_done;
    error_nxt     = error;
    err_index_nxt = err_index;
    usr_word_nxt  = usr_word;
    case (state)
      ST_ISSUE: begin
        start_nxt    = 1'b1;
        i2c_data_nxt = {DEV_ADDR, is_user ? usr_word : cfg_word(5'(status))};
      end
      ST_WAIT: begin
        if (done_seen) begin
          if (i2c_ack) begin
            if (!is_user) begin
              retry_nxt = '0;
              if (is_last) init_done_nxt = 1'b1;
              else         status_nxt    = status + IDX_W'(1);
            end
          end else if (can_retry) begin
            retry_nxt = retry + RTY_W'(1);
          end else begin
            error_nxt     = 1'b1;
            err_index_nxt = status;
          end
        end
      end
      ST_READY, ST_ERROR: begin
        if (restart) begin
          status_nxt    = '0;
          retry_nxt     = '0;
          init_done_nxt = 1'b0;
          error_nxt     = 1'b0;
        end else if (state == ST_READY && usr_valid) begin
          usr_word_nxt = usr_data;
          status_nxt   = IDX_W'(DEPTH);
        end
      end
      default: ;
    endcase
    usr_ready_nxt = (state_next == ST_READY);
    busy_nxt      = (state_next == ST_ISSUE) || (state_next == ST_WAIT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      status    <= '0;
      retry     <= '0;
      i2c_start <= 1'b0;
      i2c_data  <= '0;
      init_done <= 1'b0;
      error     <= 1'b0;
      err_index <= '0;
      usr_ready <= 1'b0;
      busy      <= 1'b1;
    end else begin
      status    <= status_nxt;
      retry     <= retry_nxt;
      i2c_start <= start_nxt;
      i2c_data  <= i2c_data_nxt;
      init_done <= init_done_nxt;
      error     <= error_nxt;
      err_index <= err_index_nxt;
      usr_ready <= usr_ready_nxt;
      busy      <= busy_nxt;
    end
  end

  // The user word is payload only; its value is irrelevant until a write is accepted.
  always_ff @(posedge clk) begin
    usr_word <= usr_word_nxt;
  end

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Directed bench for i2c_cfg_sequencer: a scripted controller model answers each
// start, and a scoreboard queue holds the transfer words expected in order.
module tb_i2c_cfg_sequencer;

  localparam int DEPTH = 11;
  localparam int IDX_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             restart = 1'b0;
  logic             usr_valid = 1'b0;
  logic [15:0]      usr_data = '0;
  logic             usr_ready;
  logic             i2c_start;
  logic [23:0]      i2c_data;
  logic             i2c_done = 1'b0;
  logic             i2c_ack = 1'b0;
  logic             busy;
  logic             init_done;
  logic             error;
  logic [IDX_W-1:0] err_index;
  logic [IDX_W-1:0] status;

  i2c_cfg_sequencer #(.DEPTH(DEPTH), .DEV_ADDR(8'h34), .MAX_RETRY(3)) dut (
    .clk(clk), .reset(reset), .restart(restart),
    .usr_valid(usr_valid), .usr_data(usr_data), .usr_ready(usr_ready),
    .i2c_start(i2c_start), .i2c_data(i2c_data), .i2c_done(i2c_done), .i2c_ack(i2c_ack),
    .busy(busy), .init_done(init_done), .error(error),
    .err_index(err_index), .status(status)
  );

  always #5 clk = ~clk;

  int          compared = 0;
  int          mismatched = 0;
  int          starts = 0;
  logic [23:0] exp_q [$];
  logic [23:0] last_exp = '0;

  logic [15:0] tbl [DEPTH] = '{16'h0c10, 16'h0017, 16'h0217, 16'h0479, 16'h0679, 16'h08d0,
                               16'h0a04, 16'h0e01, 16'h1020, 16'h0c00, 16'h1201};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_table(input int from, input int to);
    for (int i = from; i <= to; i++) exp_q.push_back({8'h34, tbl[i]});
  endtask

  task automatic chk_reset_vals();
    chk("rst_start", 32'(i2c_start), 0);
    chk("rst_data", 32'(i2c_data), 0);
    chk("rst_status", 32'(status), 0);
    chk("rst_init_done", 32'(init_done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_err_index", 32'(err_index), 0);
    chk("rst_usr_ready", 32'(usr_ready), 0);
  endtask

  // Scoreboard: every start must match the oldest outstanding expected word.
  always @(negedge clk) begin
    if (!reset && i2c_start) begin
      starts++;
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $error("FAIL unexpected_start: observed %0h expected no start", i2c_data);
      end else begin
        last_exp = exp_q.pop_front();
        chk("start_data", 32'(i2c_data), 32'(last_exp));
      end
    end
  end

  task automatic wait_start(output bit ok);
    int n = 0;
    ok = 1'b1;
    while (!i2c_start && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!i2c_start) begin
      ok = 1'b0;
      compared++;
      mismatched++;
      $error("FAIL start_timeout: observed no start expected i2c_start within 200 cycles");
    end
  endtask

  // Controller model: answer the next start with ack/nack; 'early' also drives a
  // bogus NACK done during the start cycle, which the DUT has to disregard.
  task automatic serve(input logic ack, input bit early);
    bit ok;
    wait_start(ok);
    if (!ok) return;
    if (early) begin
      i2c_done = 1'b1;
      i2c_ack  = 1'b0;
    end
    @(negedge clk);
    i2c_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("data_hold", 32'(i2c_data), 32'(last_exp));
    i2c_done = 1'b1;
    i2c_ack  = ack;
    @(negedge clk);
    i2c_done = 1'b0;
    i2c_ack  = 1'b0;
    chk("data_hold_after_done", 32'(i2c_data), 32'(last_exp));
  endtask

  initial begin
    int n;
    bit ok;

    // Reset values
    repeat (3) @(negedge clk);
    chk_reset_vals();

    // Full init table, controller always acks
    push_table(0, DEPTH - 1);
    reset = 1'b0;
    serve(1'b1, 1'b1);
    for (int i = 1; i < DEPTH; i++) begin
      if (i == DEPTH - 1) chk("init_done_before_last", 32'(init_done), 0);
      serve(1'b1, 1'b0);
    end
    chk("init_done_after_table", 32'(init_done), 1);
    chk("usr_ready_after_table", 32'(usr_ready), 1);
    chk("busy_in_ready", 32'(busy), 0);
    chk("error_after_table", 32'(error), 0);
    chk("status_after_table", 32'(status), DEPTH - 1);

    // Runtime user write
    usr_valid = 1'b1;
    usr_data  = 16'h047f;
    exp_q.push_back(24'h34047f);
    @(negedge clk);
    usr_valid = 1'b0;
    chk("usr_ready_low_after_accept", 32'(usr_ready), 0);
    chk("status_user", 32'(status), DEPTH);
    chk("busy_user", 32'(busy), 1);
    serve(1'b1, 1'b0);
    chk("usr_ready_after_user", 32'(usr_ready), 1);
    chk("status_after_user", 32'(status), DEPTH);
    chk("init_done_kept", 32'(init_done), 1);

    // Restart beats a simultaneous user write; index 3 NACKed twice then acked
    usr_valid = 1'b1;
    usr_data  = 16'h1234;
    restart   = 1'b1;
    push_table(0, 3);
    push_table(3, 3);
    push_table(3, DEPTH - 1);
    exp_q.push_back(24'h341234);
    @(negedge clk);
    restart = 1'b0;
    chk("restart_init_done", 32'(init_done), 0);
    chk("restart_usr_ready", 32'(usr_ready), 0);
    chk("restart_status", 32'(status), 0);
    for (int i = 0; i < 3; i++) serve(1'b1, 1'b0);
    serve(1'b0, 1'b0);
    serve(1'b0, 1'b0);
    serve(1'b1, 1'b0);
    for (int i = 4; i < DEPTH; i++) serve(1'b1, 1'b0);
    chk("retry_init_done", 32'(init_done), 1);
    chk("retry_error", 32'(error), 0);
    chk("pending_usr_ready", 32'(usr_ready), 1);
    @(negedge clk);
    usr_valid = 1'b0;
    chk("pending_accepted_status", 32'(status), DEPTH);
    chk("pending_accepted_ready", 32'(usr_ready), 0);
    serve(1'b1, 1'b0);
    chk("pending_done_ready", 32'(usr_ready), 1);

    // Retry exhaustion at index 5
    restart = 1'b1;
    push_table(0, 5);
    for (int i = 0; i < 3; i++) push_table(5, 5);
    @(negedge clk);
    restart = 1'b0;
    for (int i = 0; i < 5; i++) serve(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) serve(1'b0, 1'b0);
    chk("exhaust_error", 32'(error), 1);
    chk("exhaust_err_index", 32'(err_index), 5);
    chk("exhaust_busy", 32'(busy), 0);
    n = starts;
    usr_valid = 1'b1;
    usr_data  = 16'h5555;
    repeat (20) @(negedge clk);
    chk("error_usr_ready", 32'(usr_ready), 0);
    chk("error_no_starts", 32'(starts), 32'(n));
    chk("error_sticky", 32'(error), 1);
    usr_valid = 1'b0;

    // Restart out of ERROR, ignored restart in WAIT, then reset mid-transfer at index 6
    restart = 1'b1;
    push_table(0, 6);
    @(negedge clk);
    restart = 1'b0;
    chk("error_cleared", 32'(error), 0);
    for (int i = 0; i < 6; i++) serve(1'b1, 1'b0);
    wait_start(ok);
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chk("restart_ignored_status", 32'(status), 6);
    chk("restart_ignored_busy", 32'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals();
    chk("queue_drained", 32'(exp_q.size()), 0);
    push_table(0, DEPTH - 1);
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) serve(1'b1, 1'b0);
    chk("post_reset_init_done", 32'(init_done), 1);
    chk("post_reset_queue", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
